// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART transmit control blocks: the sequencer
// state encoding, the UART byte width and a small index helper.
package uart_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ARB        = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_e;

  // Next index after idx in a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority search: first set bit of mask at or above ptr,
// wrapping from N-1 back to 0. Purely combinational.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_valid
);

  // Scan offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    // NOTE: every output gets a default before the search so no path
    // leaves it unassigned, which would otherwise infer a latch.
    winner    = '0;
    any_valid = |mask;
    for (int k = N - 1; k >= 0; k--) begin
      if (mask[(int'(ptr) + k) % N]) begin
        winner = IDX_W'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte
// streams. A packet (bytes up to and including req_last) holds the grant
// so packets from different requesters never interleave.
// Optional build macro UART_ARB_LOCK_TIMEOUT_EN: releases a lock whose
// owner has been idle for LOCK_TIMEOUT cycles and adds a lock_timeout pulse.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_byte,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      uart_transmit,
  output logic [BYTE_W-1:0]         uart_tx_byte,
  input  logic                      uart_busy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      locked,
`ifdef UART_ARB_LOCK_TIMEOUT_EN
  output logic                      lock_timeout,
`endif
  output logic                      busy
);

  state_e              state, state_next;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     pick_ptr;
  logic [ID_W-1:0]     winner;
  logic [NUM_REQ-1:0]  elig_mask;
  logic                any_elig;
  logic                accept;

  // While locked only the owner of the open packet may be picked.
  always_comb begin
    elig_mask = req_valid;
    pick_ptr  = rr_ptr;
    if (locked) begin
      elig_mask           = '0;
      elig_mask[grant_id] = req_valid[grant_id];
      pick_ptr            = grant_id;
    end
  end

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .mask      (elig_mask),
    .ptr       (pick_ptr),
    .winner    (winner),
    .any_valid (any_elig)
  );

  // Transfer happens in the ARB cycle that has an eligible winner; reset
  // suppresses it so req_ready is quiet while rst is held.
  assign accept        = !rst && (state == ARB) && any_elig;
  assign uart_transmit = (state == ISSUE);
  assign busy          = (state != ARB);

  // One-hot ready for the winner in the transfer cycle.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  // Byte sequencing: pulse transmit, then follow the UART busy flag.
  always_comb begin
    state_next = state;
    case (state)
      ARB:        if (accept)    state_next = ISSUE;
      ISSUE:                     state_next = WAIT_START;
      WAIT_START: if (uart_busy) state_next = WAIT_DONE;
      WAIT_DONE:  if (!uart_busy) state_next = ARB;
      default:                   state_next = ARB;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (rst) state <= ARB;
    else     state <= state_next;
  end

`ifdef UART_ARB_LOCK_TIMEOUT_EN
  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);

  logic [TO_W-1:0] idle_cnt;
  logic            lock_idle;
  logic            to_fire;

  assign lock_idle = (state == ARB) && locked && !req_valid[grant_id];
  assign to_fire   = lock_idle && (idle_cnt == TO_W'(LOCK_TIMEOUT - 1));

  // Idle counter for the lock owner; the release pulse is registered so it
  // lines up with locked falling.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt     <= '0;
      lock_timeout <= 1'b0;
    end else begin
      lock_timeout <= to_fire;
      if (accept || to_fire) idle_cnt <= '0;
      else if (lock_idle)    idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  // The timeout length only matters when the release feature is built in.
  logic unused_lock_timeout;
  assign unused_lock_timeout = (LOCK_TIMEOUT > 0);
`endif

  // Grant bookkeeping and the byte latched for the UART on each transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      grant_id     <= '0;
      locked       <= 1'b0;
      uart_tx_byte <= '0;
    end else if (accept) begin
      uart_tx_byte <= req_byte[int'(winner)*BYTE_W +: BYTE_W];
      grant_id     <= winner;
      locked       <= ~req_last[winner];
      if (req_last[winner]) rr_ptr <= ID_W'(wrap_inc(int'(winner), NUM_REQ));
    end
`ifdef UART_ARB_LOCK_TIMEOUT_EN
    else if (to_fire) begin
      locked <= 1'b0;
      rr_ptr <= ID_W'(wrap_inc(int'(grant_id), NUM_REQ));
    end
`endif
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a queue-based
// requester model and a simple UART busy model.
module tb_uart_tx_arbiter;
  import uart_ctrl_pkg::*;

  localparam int NUM_REQ      = 4;
  localparam int ID_W         = 2;
  localparam int LOCK_TIMEOUT = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_byte;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 uart_transmit;
  logic [7:0]           uart_tx_byte;
  logic                 uart_busy;
  logic [ID_W-1:0]      grant_id;
  logic                 locked;
  logic                 busy;
`ifdef UART_ARB_LOCK_TIMEOUT_EN
  logic                 lock_timeout;
`endif

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .ID_W         (ID_W),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_byte      (req_byte),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .uart_transmit (uart_transmit),
    .uart_tx_byte  (uart_tx_byte),
    .uart_busy     (uart_busy),
    .grant_id      (grant_id),
    .locked        (locked),
`ifdef UART_ARB_LOCK_TIMEOUT_EN
    .lock_timeout  (lock_timeout),
`endif
    .busy          (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requester model: queue of {last, byte} per requester, popped after ready.
  logic [8:0]         src_q [NUM_REQ][$];
  logic [NUM_REQ-1:0] pop_pend = '0;

  initial forever begin
    @(negedge clk);
    pop_pend = req_ready;
  end

  initial begin
    req_valid = '0;
    req_byte  = '0;
    req_last  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pop_pend[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        if (src_q[i].size() != 0) begin
          req_valid[i]       = 1'b1;
          req_byte[8*i +: 8] = src_q[i][0][7:0];
          req_last[i]        = src_q[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // UART model: start_dly cycles after the transmit pulse busy rises for
  // frame cycles. Logs every transmitted byte and any extra pulses.
  int         start_dly = 1;
  int         frame     = 4;
  int         phase     = 0;
  int         dcnt      = 0;
  int         fcnt      = 0;
  int         extra_tx  = 0;
  logic [7:0] tx_log [$];

  initial begin
    uart_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        uart_busy = 1'b0;
        phase     = 0;
      end else begin
        case (phase)
          0: if (uart_transmit) begin
               tx_log.push_back(uart_tx_byte);
               dcnt  = start_dly;
               phase = 1;
             end
          1: begin
               if (uart_transmit) extra_tx++;
               dcnt--;
               if (dcnt <= 0) begin
                 uart_busy = 1'b1;
                 fcnt      = frame;
                 phase     = 2;
               end
             end
          default: begin
               if (uart_transmit) extra_tx++;
               fcnt--;
               if (fcnt <= 0) begin
                 uart_busy = 1'b0;
                 phase     = 0;
               end
             end
        endcase
      end
    end
  end

`ifdef UART_ARB_LOCK_TIMEOUT_EN
  int to_pulses = 0;
  initial forever begin
    @(negedge clk);
    if (lock_timeout === 1'b1) to_pulses++;
  end
`endif

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_log(input string tag, input int n);
    int t = 0;
    while ((tx_log.size() < n || busy) && t < 400) begin
      step();
      t++;
    end
    check(tag, 32'(tx_log.size() >= n && !busy), 32'd1);
  endtask

  logic [7:0] exp_round [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11, 8'h12, 8'h13};
  logic [7:0] exp_lock  [4] = '{8'h1A, 8'h1B, 8'h1C, 8'hA0};

  initial begin
    int base;
    int t;
    rst = 1'b1;
    step();
    step();
    check("rst_ready",    32'(req_ready),     32'h0);
    check("rst_transmit", 32'(uart_transmit), 32'h0);
    check("rst_tx_byte",  32'(uart_tx_byte),  32'h0);
    check("rst_grant",    32'(grant_id),      32'h0);
    check("rst_locked",   32'(locked),        32'h0);
    check("rst_busy",     32'(busy),          32'h0);
    rst = 1'b0;

    // Single byte from requester 2.
    src_q[2].push_back({1'b1, 8'h5A});
    for (t = 0; t < 20 && req_ready == '0; t++) step();
    check("t1_ready",    32'(req_ready),     32'h4);
    check("t1_busy_arb", 32'(busy),          32'h0);
    step();
    check("t1_transmit", 32'(uart_transmit), 32'h1);
    check("t1_tx_byte",  32'(uart_tx_byte),  32'h5A);
    check("t1_grant",    32'(grant_id),      32'h2);
    check("t1_locked",   32'(locked),        32'h0);
    check("t1_ready_off",32'(req_ready),     32'h0);
    step();
    check("t1_pulse_end",32'(uart_transmit), 32'h0);
    wait_log("t1_done", 1);
    check("t1_line",     32'(tx_log[0]),     32'h5A);
    check("t1_rr_ptr",   32'(dut.rr_ptr),    32'h3);

    // Four requesters, two rounds, pointer restarted from 0 by reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    base = tx_log.size();
    for (int i = 0; i < NUM_REQ; i++) begin
      src_q[i].push_back({1'b1, 8'(8'h10 + i)});
      src_q[i].push_back({1'b1, 8'(8'h10 + i)});
    end
    wait_log("t2_done", base + 8);
    for (int k = 0; k < 8; k++) check($sformatf("t2_order%0d", k), 32'(tx_log[base+k]), 32'(exp_round[k]));

    // Packet lock: requester 0 first moves the pointer to 1.
    base = tx_log.size();
    src_q[0].push_back({1'b1, 8'h0F});
    wait_log("t3_pre", base + 1);
    src_q[1].push_back({1'b0, 8'h1A});
    src_q[1].push_back({1'b0, 8'h1B});
    src_q[1].push_back({1'b1, 8'h1C});
    src_q[0].push_back({1'b1, 8'hA0});
    for (t = 0; t < 100 && !req_ready[1]; t++) step();
    check("t3_grab",   32'(req_ready),  32'h2);
    step();
    check("t3_locked", 32'(locked),     32'h1);
    check("t3_grant",  32'(grant_id),   32'h1);
    for (t = 0; t < 100 && busy; t++) step();
    check("t3_between_locked", 32'(locked), 32'h1);
    check("t3_between_ready",  32'(req_ready), 32'h2);
    wait_log("t3_done", base + 5);
    for (int k = 0; k < 4; k++) check($sformatf("t3_order%0d", k), 32'(tx_log[base+1+k]), 32'(exp_lock[k]));
    check("t3_unlocked", 32'(locked), 32'h0);

    // Transmit spacing: UART slow to go busy.
    start_dly = 5;
    base = tx_log.size();
    src_q[2].push_back({1'b1, 8'h77});
    src_q[3].push_back({1'b1, 8'h88});
    for (t = 0; t < 50 && !uart_transmit; t++) step();
    check("t4_pulse", 32'(uart_transmit), 32'h1);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("t4_state%0d", k), 32'(dut.state),     32'(WAIT_START));
      check($sformatf("t4_tx%0d", k),    32'(uart_transmit), 32'h0);
      check($sformatf("t4_rdy%0d", k),   32'(req_ready),     32'h0);
    end
    wait_log("t4_done", base + 2);
    check("t4_first",  32'(tx_log[base]),   32'h77);
    check("t4_second", 32'(tx_log[base+1]), 32'h88);
    check("t4_no_extra_tx", 32'(extra_tx), 32'h0);
    start_dly = 1;

    // Reset during WAIT_DONE; requester 1's grant moves the pointer to 2.
    src_q[1].push_back({1'b1, 8'h31});
    for (t = 0; t < 50 && dut.state != WAIT_DONE; t++) step();
    check("t5_reach", 32'(dut.state), 32'(WAIT_DONE));
    rst = 1'b1;
    step();
    check("t5_busy",     32'(busy),          32'h0);
    check("t5_locked",   32'(locked),        32'h0);
    check("t5_ready",    32'(req_ready),     32'h0);
    check("t5_grant",    32'(grant_id),      32'h0);
    check("t5_transmit", 32'(uart_transmit), 32'h0);
    rst = 1'b0;
    base = tx_log.size();
    src_q[0].push_back({1'b1, 8'h50});
    src_q[2].push_back({1'b1, 8'h52});
    wait_log("t5_done", base + 2);
    check("t5_first",  32'(tx_log[base]),   32'h50);
    check("t5_second", 32'(tx_log[base+1]), 32'h52);

`ifdef UART_ARB_LOCK_TIMEOUT_EN
    // Requester 3 opens a packet then goes idle; pointer is 3 here.
    base = tx_log.size();
    src_q[3].push_back({1'b0, 8'hC0});
    src_q[0].push_back({1'b1, 8'hD0});
    for (t = 0; t < 80 && lock_timeout !== 1'b1; t++) step();
    check("to_pulse",  32'(lock_timeout), 32'h1);
    check("to_locked", 32'(locked),       32'h0);
    wait_log("to_done", base + 2);
    check("to_first",  32'(tx_log[base]),   32'hC0);
    check("to_next",   32'(tx_log[base+1]), 32'hD0);
    check("to_count",  32'(to_pulses),      32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
